// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a 2-entry skid buffer.
// Upstream may keep issuing for one cycle after downstream back-pressure,
// and in_ready is a pure register with no combinational path from out_ready.
// A synchronous flush drops everything held and leaves a bubble with zero control.
//
// Optional build macro: PIPE_SKID_STAGE_PERF_EN
//   When defined, this adds input cnt_clr and output stall_cnt[31:0].
//   stall_cnt is a saturating count of cycles with out_valid=1 and out_ready=0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_EMPTY | nothing held; out_valid=0, in_ready=1
// S_ONE   | main register holds the word on out_*; in_ready=1
// S_TWO   | main and skid both hold words; in_ready=0 until main drains
module pipe_skid_stage #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 126
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  input  logic              cnt_clr,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_TWO   = 2'b10;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  logic in_xfer;
  logic out_xfer;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;
  logic clr_main_ctrl;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and register-load selection; flush overrides every transition
  always_comb begin
    state_d       = state_q;
    ld_main_in    = 1'b0;
    ld_main_skid  = 1'b0;
    ld_skid       = 1'b0;
    clr_main_ctrl = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d    = S_ONE;
          ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          ld_main_in = 1'b1;
        end else if (in_xfer) begin
          state_d = S_TWO;
          ld_skid = 1'b1;
        end else if (out_xfer) begin
          state_d       = S_EMPTY;
          clr_main_ctrl = 1'b1;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (out_xfer) begin
          state_d      = S_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: begin
        state_d       = S_EMPTY;
        clr_main_ctrl = 1'b1;
      end
    endcase
    if (flush) begin
      state_d       = S_EMPTY;
      ld_main_in    = 1'b0;
      ld_main_skid  = 1'b0;
      ld_skid       = 1'b0;
      clr_main_ctrl = 1'b1;
    end
  end

  // State plus registered handshake outputs, all derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != S_EMPTY);
      in_ready  <= (state_d != S_TWO);
    end
  end

  // Main control register; it is zeroed whenever the stage goes empty, so a bubble carries no enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ctrl <= '0;
    end else if (clr_main_ctrl) begin
      out_ctrl <= '0;
    end else if (ld_main_in) begin
      out_ctrl <= in_ctrl;
    end else if (ld_main_skid) begin
      out_ctrl <= skid_ctrl_q;
    end
  end

  // Main datapath register; it holds its last value while the stage is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (ld_main_in) begin
      out_data <= in_data;
    end else if (ld_main_skid) begin
      out_data <= skid_data_q;
    end
  end

  // Skid register captures the word accepted in the cycle back-pressure began
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (ld_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_data_q <= in_data;
    end
  end

`ifdef PIPE_SKID_STAGE_PERF_EN
  // Saturating stall counter; a clear wins over an increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // Upstream must hold an offer steady until it is taken
  a_in_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_ctrl) && $stable(in_data)));

  // A bubble never carries control bits
  a_bubble_ctrl : assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> (out_ctrl == '0));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage. A queue-based model of the stage
// (at most two words, first in first out) is checked on every falling edge.
// Directed cases pin the model with literal values; random traffic follows.
module tb_pipe_skid_stage;
  localparam int CW = 9;
  localparam int DW = 126;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic          cnt_clr;
  logic [31:0]   stall_cnt;
  logic [31:0]   exp_stall;
  logic          s_clr;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  word_t q[$];
  word_t s_w;
  logic  s_iv, s_ir, s_or, s_fl;
  bit    in_x, out_x;

  // Sample pre-edge values and compare the DUT against the model's contents
  always @(negedge clk) begin
    if (!rst_n) begin
      s_iv = 1'b0; s_ir = 1'b1; s_or = 1'b0; s_fl = 1'b0;
      s_w  = '0;
`ifdef PIPE_SKID_STAGE_PERF_EN
      s_clr = 1'b0;
`endif
    end else begin
      s_iv   = in_valid; s_ir = in_ready; s_or = out_ready; s_fl = flush;
      s_w.c  = in_ctrl;
      s_w.d  = in_data;
`ifdef PIPE_SKID_STAGE_PERF_EN
      s_clr = cnt_clr;
      chk("m_stall_cnt", 128'(stall_cnt), 128'(exp_stall));
`endif
      chk("m_out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("m_in_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() > 0) begin
        chk("m_out_ctrl", 128'(out_ctrl), 128'(q[0].c));
        chk("m_out_data", 128'(out_data), 128'(q[0].d));
      end else begin
        chk("m_bubble_ctrl", 128'(out_ctrl), 128'(0));
      end
    end
  end

  // Model update: at most two words held, oldest on the output
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
`ifdef PIPE_SKID_STAGE_PERF_EN
      exp_stall = 32'd0;
`endif
    end else begin
      in_x  = s_iv && (q.size() < 2);
      out_x = (q.size() > 0) && s_or;
`ifdef PIPE_SKID_STAGE_PERF_EN
      if (s_clr) exp_stall = 32'd0;
      else if (q.size() > 0 && !s_or && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
      if (s_fl) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(s_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] c, input int k);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = DW'(k);
  endtask

  logic [127:0] rnd;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
`ifdef PIPE_SKID_STAGE_PERF_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));

    // Stream words 1..8 at full rate
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      offer(9'h1A5, k);
      tick();
      chk("str_valid", 128'(out_valid), 128'(1));
      chk("str_ctrl", 128'(out_ctrl), 128'(9'h1A5));
      chk("str_data", 128'(out_data), 128'(k));
      chk("str_ready", 128'(in_ready), 128'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("str_end_valid", 128'(out_valid), 128'(0));
    chk("str_end_ctrl", 128'(out_ctrl), 128'(0));

    // Back-pressure: one extra word is taken into the skid, then in_ready drops
    offer(9'h1A5, 20);
    tick();
    chk("bp_data20", 128'(out_data), 128'(20));
    out_ready = 1'b0;
    offer(9'h1A5, 21);
    tick();
    chk("bp_ready_low", 128'(in_ready), 128'(0));
    chk("bp_hold20", 128'(out_data), 128'(20));
    offer(9'h1A5, 22);
    repeat (3) begin
      tick();
      chk("bp_stall_ready", 128'(in_ready), 128'(0));
      chk("bp_stall_data", 128'(out_data), 128'(20));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drain_data21", 128'(out_data), 128'(21));
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    tick();
    chk("bp_data22", 128'(out_data), 128'(22));
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 128'(out_valid), 128'(0));

    // Flush while two words (5, 6) are held
    out_ready = 1'b0;
    offer(9'h1A5, 5);
    tick();
    offer(9'h1A5, 6);
    tick();
    chk("fl_two", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    chk("fl_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_stays_empty", 128'(out_valid), 128'(0));
    end

    // Flush together with an accepted word 9; word 10 follows normally
    offer(9'h0F3, 9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(9'h0F3, 10);
    chk("flx_no9", 128'(out_valid), 128'(0));
    tick();
    chk("flx_valid10", 128'(out_valid), 128'(1));
    chk("flx_data10", 128'(out_data), 128'(10));
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while holding two words
    out_ready = 1'b0;
    offer(9'h155, 30);
    tick();
    offer(9'h155, 31);
    tick();
    offer(9'h155, 32);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid), 128'(0));
    chk("ar_ctrl", 128'(out_ctrl), 128'(0));
    chk("ar_data", 128'(out_data), 128'(0));
    chk("ar_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_ready_after", 128'(in_ready), 128'(1));
    chk("ar_valid_after", 128'(out_valid), 128'(0));

`ifdef PIPE_SKID_STAGE_PERF_EN
    chk("pf_zero", 128'(stall_cnt), 128'(0));
    offer(9'h1A5, 40);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("pf_seven", 128'(stall_cnt), 128'(7));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("pf_clr", 128'(stall_cnt), 128'(0));
    out_ready = 1'b1;
    tick();
`endif

    // Random traffic obeying the upstream hold rule
    for (int i = 0; i < 4000; i++) begin
      if (!(in_valid && !s_ir)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rnd      = {$urandom, $urandom, $urandom, $urandom};
        in_ctrl  = CW'($urandom);
        in_data  = rnd[DW-1:0];
      end
      if (i < 2000) out_ready = ($urandom_range(0, 9) < 6);
      else          out_ready = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
`ifdef PIPE_SKID_STAGE_PERF_EN
      cnt_clr = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
`ifdef PIPE_SKID_STAGE_PERF_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake. It succeeds the fixed-field, always-load inter-stage registers.
- A 2-entry skid buffer lets an upstream stage keep issuing for one cycle after downstream back-pressure, without a combinational ready path.
- A synchronous flush inserts a bubble with zeroed control.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Control (WB/M/EX bits) and datapath fields are carried as separate packed vectors.

Parameters:
- CTRL_W, 9, width of packed control field (WB 2 + M 2 + EX 5).
- DATA_W, 126, width of packed datapath field (RT data, srcl, shamt, sign-ext, R/I addr, Rs, Rt, Rd).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous bubble insert; highest priority.
- in_valid  input  1  upstream offers in_ctrl/in_data.
- in_ready  output  1  stage can accept; registered output.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream datapath field.
- out_valid  output  1  out_ctrl/out_data hold a live instruction.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  control to next stage; all-zero whenever out_valid=0.
- out_data  output  DATA_W  datapath to next stage.

Behaviour:
- Handshake events:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Data moves only on these events.
  - Once asserted, in_valid must not drop and in_data/in_ctrl must not change until the transfer completes (upstream rule; checked by assertion).
- Storage:
  - main register (drives out_*).
  - skid register.
  - 2-bit state: EMPTY, ONE, TWO.
- Reset (rst_n=0, async):
  - state=EMPTY, out_valid=0, out_ctrl=0, out_data=0.
  - skid cleared.
  - in_ready=1, visible from the first cycle after reset deasserts.
- Transitions (flush=0):
  - EMPTY:
    - in_xfer -> ONE, main<=in.
    - else stay.
  - ONE:
    - in_xfer & out_xfer -> ONE, main<=in.
    - in_xfer & !out_xfer -> TWO, skid<=in, main held.
    - !in_xfer & out_xfer -> EMPTY.
    - neither -> hold.
  - TWO:
    - out_xfer -> ONE, main<=skid.
    - else hold.
    - in_ready=0 in this state, so no in_xfer can occur.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO, updated with next state. No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY), registered.
- Latency and throughput:
  - 1 cycle from in_xfer to out_valid with the same payload.
  - Full throughput (1 per cycle) while out_ready=1.
  - Ordering strictly FIFO; no drop, no duplicate.
- Flush (synchronous, overrides all other transitions):
  - Next state EMPTY, out_valid<=0, out_ctrl<=0, in_ready<=1.
  - Both main and skid entries discarded; any in_xfer in the flush cycle is discarded.
  - out_data holds its previous value (don't-care while invalid).
- Bubble rule: out_ctrl is all-zero whenever out_valid=0, so downstream register-write/memory-write enables stay inactive without gating.
- Simultaneous flush with out_xfer: the downstream consumes the current word that cycle; the stage is empty after the edge.
- Reset mid-operation clears everything regardless of state or handshake.

Optional Feature:
- Macro: PIPE_SKID_STAGE_PERF_EN.
- Defined:
  - Adds output stall_cnt [31:0] and input cnt_clr (synchronous).
  - stall_cnt increments by 1 on every cycle with out_valid=1 & out_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst_n=0 or cnt_clr=1; cnt_clr has priority over increment.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan:
- Reset then stream: rst_n low 3 cycles, release; in_valid=1 with ctrl 9'h1A5 / data k for k=1..8, out_ready=1 -> out_valid rises 1 cycle after the first accept; outputs 1..8 in consecutive cycles; in_ready stays 1.
- Back-pressure skid: stream running, out_ready=0 for 4 cycles -> exactly one extra word accepted, then in_ready=0 next cycle. On out_ready=1, the held words emerge in order with no loss, and in_ready returns 1 one cycle after the first drain.
- Flush in TWO: fill to TWO with words 5, 6; assert flush 1 cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Neither 5 nor 6 ever appears at the output.
- Flush with concurrent input: flush=1 and in_xfer of word 9 in the same cycle -> word 9 is never output; next accepted word 10 appears with 1-cycle latency.
- Async reset mid-stream in TWO: pulse rst_n low between clock edges -> out_valid, out_ctrl, out_data go 0 immediately (no clock edge needed); in_ready=1 after release.
- PERF (macro defined): out_valid=1 with out_ready=0 for 7 cycles -> stall_cnt=7; cnt_clr pulse -> 0; preload near max -> saturates at FFFFFFFF.
